// File: rtl/block_stack_pkg.sv
// Shared definitions for the block-stacking game.
// Holds the FSM state encoding, the shift direction type and the
// default playfield geometry used by block_stack_fsm and its shifter.
package block_stack_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_MOVE = 3'd2,
    ST_LOCK = 3'd3,
    ST_WIN  = 3'd4,
    ST_LOSE = 3'd5
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int         NUM_ROWS  = 8;
  localparam logic [7:0] START_SEG = 8'b0000_0111;
  localparam int         ROW_W     = 3;
  localparam logic [3:0] SCORE_MAX = 4'd8;

endpackage

// File: rtl/block_stack_shifter.sv
// Next-position logic for the moving segment.
// Ports:
//   seg      - current segment (bit i = column i)
//   dir      - current direction of travel
//   seg_next - segment after one move
//   dir_next - direction after one move (flipped on a bounce)
// A segment touching the wall it is heading for reverses and moves away
// on the same step; a full-width segment cannot move and holds.
module block_stack_shifter
  import block_stack_pkg::*;
(
  input  logic [7:0] seg,
  input  dir_e       dir,
  output logic [7:0] seg_next,
  output dir_e       dir_next
);

  always_comb begin
    seg_next = seg;
    dir_next = dir;
    if (seg != 8'hFF) begin
      if (dir == DIR_LEFT) begin
        if (seg[7]) begin
          dir_next = DIR_RIGHT;
          seg_next = seg >> 1;
        end else begin
          seg_next = seg << 1;
        end
      end else begin
        if (seg[0]) begin
          dir_next = DIR_LEFT;
          seg_next = seg << 1;
        end else begin
          seg_next = seg >> 1;
        end
      end
    end
  end

endmodule

// File: rtl/block_stack_fsm.sv
// Block-stacking game controller.
// Clears the display, then lets a segment slide back and forth on the
// current row; each lock keeps only the columns supported by the row
// below. Reaching the top row wins, losing all columns loses.
// Ports:
//   board_clk    - clock, rising edge
//   reset        - asynchronous active-high reset
//   tick         - move-enable pulse
//   btn_scen     - lock / restart pulse
//   start        - level, sampled only in IDLE
//   row_data     - row contents for the display (bit i = column i)
//   row_index    - destination row, 0 = bottom
//   write_strobe - one-cycle display write pulse
//   score        - rows locked successfully (saturates at 8)
//   state        - FSM state encoding
//   win, lose    - game result flags
module block_stack_fsm #(
  parameter int         NUM_ROWS  = block_stack_pkg::NUM_ROWS,
  parameter logic [7:0] START_SEG = block_stack_pkg::START_SEG
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_scen,
  input  logic       start,
  output logic [7:0] row_data,
  output logic [2:0] row_index,
  output logic       write_strobe,
  output logic [3:0] score,
  output logic [2:0] state,
  output logic       win,
  output logic       lose
);
  import block_stack_pkg::*;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  function automatic logic [3:0] score_sat_inc(input logic [3:0] s);
    return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       seg_q, seg_d;
  dir_e             dir_q, dir_d;
  logic [7:0]       below_q, below_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [3:0]       score_q, score_d;
  logic [7:0]       row_data_q, row_data_d;
  logic [2:0]       row_index_q, row_index_d;
  logic             strobe_q, strobe_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;

  logic [7:0] seg_nx;
  dir_e       dir_nx;
  logic [7:0] locked;

  block_stack_shifter u_shifter (
    .seg      (seg_q),
    .dir      (dir_q),
    .seg_next (seg_nx),
    .dir_next (dir_nx)
  );

  assign locked = seg_q & below_q;

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    dir_d       = dir_q;
    below_d     = below_q;
    cur_row_d   = cur_row_q;
    score_d     = score_q;
    row_data_d  = row_data_q;
    row_index_d = row_index_q;
    strobe_d    = 1'b0;
    win_d       = win_q;
    lose_d      = lose_q;

    case (state_q)
      // cur_row doubles as the row counter for the clear sequence
      ST_INIT: begin
        strobe_d    = 1'b1;
        row_data_d  = 8'h00;
        row_index_d = cur_row_q;
        score_d     = 4'd0;
        win_d       = 1'b0;
        lose_d      = 1'b0;
        if (cur_row_q == LAST_ROW) begin
          cur_row_d = '0;
          state_d   = ST_IDLE;
        end else begin
          cur_row_d = cur_row_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (start) begin
          seg_d     = START_SEG;
          cur_row_d = '0;
          below_d   = 8'hFF;
          dir_d     = DIR_LEFT;
          state_d   = ST_MOVE;
        end
      end

      // Pulses landing while the previous write is still on the bus are
      // ignored, so two writes can never be back to back.
      ST_MOVE: begin
        if (!strobe_q) begin
          if (btn_scen) begin
            state_d = ST_LOCK;
          end else if (tick) begin
            seg_d       = seg_nx;
            dir_d       = dir_nx;
            strobe_d    = 1'b1;
            row_data_d  = seg_nx;
            row_index_d = cur_row_q;
          end
        end
      end

      ST_LOCK: begin
        strobe_d    = 1'b1;
        row_data_d  = locked;
        row_index_d = cur_row_q;
        if (locked == 8'h00) begin
          lose_d  = 1'b1;
          state_d = ST_LOSE;
        end else if (cur_row_q == LAST_ROW) begin
          score_d = score_sat_inc(score_q);
          win_d   = 1'b1;
          state_d = ST_WIN;
        end else begin
          score_d   = score_sat_inc(score_q);
          below_d   = locked;
          seg_d     = locked;
          cur_row_d = cur_row_q + 1'b1;
          state_d   = ST_MOVE;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (btn_scen) begin
          win_d     = 1'b0;
          lose_d    = 1'b0;
          cur_row_d = '0;
          state_d   = ST_INIT;
        end
      end

      default: begin
        cur_row_d = '0;
        state_d   = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      seg_q       <= START_SEG;
      dir_q       <= DIR_LEFT;
      below_q     <= 8'hFF;
      cur_row_q   <= '0;
      score_q     <= 4'd0;
      row_data_q  <= 8'h00;
      row_index_q <= 3'd0;
      strobe_q    <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      dir_q       <= dir_d;
      below_q     <= below_d;
      cur_row_q   <= cur_row_d;
      score_q     <= score_d;
      row_data_q  <= row_data_d;
      row_index_q <= row_index_d;
      strobe_q    <= strobe_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  assign row_data     = row_data_q;
  assign row_index    = row_index_q;
  assign write_strobe = strobe_q;
  assign score        = score_q;
  assign state        = state_q;
  assign win          = win_q;
  assign lose         = lose_q;

endmodule

// File: doc/block_stack_fsm.md
BLOCK_STACK_FSM -- requirements
Module: block_stack_fsm

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 8, giving the number of playfield rows; the row index width is 3 bits.
REQ-002 SHALL have parameter START_SEG, default 8'b0000_0111, giving the initial moving segment.
REQ-003 SHALL have port board_clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port tick, input, 1 bit: single-cycle move-enable pulse from the clock divider.
REQ-006 SHALL have port btn_scen, input, 1 bit: single-cycle debounced lock/restart pulse.
REQ-007 SHALL have port start, input, 1 bit: level; 1 permits leaving IDLE.
REQ-008 SHALL have port row_data, output, 8 bits: row contents to the display array; bit i is column i.
REQ-009 SHALL have port row_index, output, 3 bits: destination row, 0 = bottom.
REQ-010 SHALL have port write_strobe, output, 1 bit: one-cycle pulse; the display latches row_data into row_index while it is high.
REQ-011 SHALL have port score, output, 4 bits: number of rows locked successfully.
REQ-012 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-013 SHALL have port win, output, 1 bit: high in WIN.
REQ-014 SHALL have port lose, output, 1 bit: high in LOSE.

Function
REQ-015 SHALL implement states INIT=0, IDLE=1, MOVE=2, LOCK=3, WIN=4, LOSE=5.
REQ-016 INIT SHALL take 8 cycles, one per row 0..7, each issuing write_strobe with row_data=0 and row_index = row; after row 7 it SHALL go to IDLE, and score SHALL be 0 at that point.
REQ-017 IDLE SHALL wait for start=1, then load seg=START_SEG, cur_row=0, below=8'hFF, dir=left, and enter MOVE.
REQ-018 In MOVE, each tick SHALL shift seg by one column in dir, then write it: write_strobe, row_data=seg, row_index=cur_row, in the cycle after the tick.
REQ-019 Bounce rule for MOVE: if dir=left and seg[7]=1, dir SHALL flip to right and seg SHALL shift right on that same tick.
REQ-020 Bounce rule for MOVE: if dir=right and seg[0]=1, dir SHALL flip to left and seg SHALL shift left on that same tick.
REQ-021 Bounce rule for MOVE: if seg=8'hFF, seg SHALL hold and dir SHALL be unchanged.
REQ-022 In MOVE, btn_scen SHALL enter LOCK without shifting; when tick and btn_scen arrive in the same cycle, btn_scen wins and the tick is dropped.
REQ-023 LOCK SHALL last exactly 1 cycle: locked = seg AND below; it SHALL write locked to cur_row with write_strobe.
REQ-024 From LOCK, if locked=0 the FSM SHALL go to LOSE with score unchanged.
REQ-025 From LOCK, if locked!=0 and cur_row=7 the FSM SHALL go to WIN with score+1.
REQ-026 From LOCK otherwise the FSM SHALL do score+1, below=locked, seg=locked, cur_row+1, keep dir, and return to MOVE.
REQ-027 score SHALL saturate at 8 and SHALL never wrap.
REQ-028 WIN and LOSE SHALL hold all outputs; btn_scen SHALL go to INIT; tick SHALL be ignored.
REQ-029 write_strobe SHALL never be high two consecutive cycles outside INIT, and never in IDLE, WIN or LOSE.
REQ-030 start deasserted in MOVE SHALL not abort the game; start is sampled only in IDLE.

Reset
REQ-031 On reset: state=INIT, row_data=0, row_index=0, write_strobe=0, score=0, win=0, lose=0, seg=START_SEG, dir=left, below=8'hFF, cur_row=0.
REQ-032 Reset asserted mid-game SHALL abort immediately; after release the INIT clear SHALL rerun in full (8 strobes).
REQ-033 All outputs SHALL be registered.

Structure
REQ-034 State encodings, NUM_ROWS and START_SEG SHALL live in shared package block_stack_pkg.
REQ-035 Next-segment/bounce logic SHALL be one combinational sub-module, block_stack_shifter, with ports seg, dir in and seg_next, dir_next out.

Verification
REQ-036 Reset then release -> 8 strobes, row_index 0..7, row_data=0, then state=IDLE, score=0.
REQ-037 start=1 then 5 ticks -> row 0 writes 0x0E, 0x1C, 0x38, 0x70, 0xE0; a 6th tick -> 0x70 with dir=right.
REQ-038 seg=0x1C on row 0, btn -> write 0x1C to row 0, score=1; next tick writes to row 1.
REQ-039 below=0x1C, seg=0x38, btn -> row 1 gets 0x18, seg=0x18; with below=0x1C, seg=0xE0, btn -> row gets 0x00, lose=1, score held.
REQ-040 Eight successful locks -> win=1, score=8; then btn_scen -> INIT clear sequence.
REQ-041 tick and btn_scen in the same cycle -> no shift, lock of the pre-tick seg; reset during MOVE -> outputs zeroed asynchronously.
